// File: rtl/xor_parity_sched.sv
`default_nettype none
// ============================================================================
//  Module   : xor_parity_sched
//  Purpose  : Round-robin scheduler that shares one serial parity engine
//             between four requesters. The engine folds two bits per cycle
//             (acc ^ b0 ^ b1) and returns the word parity tagged with the
//             owner id.
//  Options  : XOR_SCHED_ODD_EN - when defined, parity reports odd parity.
//  Revision : 1.0 - initial release
// ============================================================================
module xor_parity_sched #(
  parameter int WIDTH = 8  // word width; must be even and at least 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req,
  input  logic [4*WIDTH-1:0]   data,
  output logic [3:0]           gnt,
  output logic                 busy,
  output logic                 done,
  output logic                 parity,
  output logic [1:0]           owner
);

  localparam int              CW   = $clog2(WIDTH/2 + 1);
  localparam logic [CW-1:0]   HALF = CW'(WIDTH/2);
  localparam logic [CW-1:0]   ONE  = CW'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

`ifdef XOR_SCHED_ODD_EN
  localparam logic ODD_INV = 1'b1;
`else
  localparam logic ODD_INV = 1'b0;
`endif

  logic [1:0]       state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       owner_next_q, owner_next_d;
  logic             done_q, done_d;
  logic             parity_q, parity_d;
  logic [1:0]       owner_q, owner_d;

  logic [1:0]       win;
  logic             found;
  logic [1:0]       idx;

  // Round-robin search: first set request starting just after the last grant
  always_comb begin
    win   = last_q;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Next-state logic for the arbiter and the two-bit-per-cycle fold loop
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    sh_d         = sh_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    gnt_d        = 4'b0000;
    owner_next_d = owner_next_q;
    done_d       = 1'b0;
    parity_d     = parity_q;
    owner_d      = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          sh_d         = data[win*WIDTH +: WIDTH];
          acc_d        = 1'b0;
          cnt_d        = HALF;
          gnt_d        = 4'b0001 << win;
          owner_next_d = win;
          last_d       = win;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_q ^ sh_q[0] ^ sh_q[1];
        sh_d  = sh_q >> 2;
        cnt_d = cnt_q - ONE;
        if (cnt_q == ONE) begin
          // Result is the accumulator including this final fold
          state_d  = ST_DONE;
          done_d   = 1'b1;
          parity_d = acc_d ^ ODD_INV;
          owner_d  = owner_next_q;
        end
      end
      ST_DONE: begin
        // Requests are deliberately not sampled here
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any word in flight without a done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_q       <= 2'd3;
      sh_q         <= '0;
      acc_q        <= 1'b0;
      cnt_q        <= '0;
      gnt_q        <= 4'b0000;
      owner_next_q <= 2'd0;
      done_q       <= 1'b0;
      parity_q     <= 1'b0;
      owner_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      sh_q         <= sh_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      owner_next_q <= owner_next_d;
      done_q       <= done_d;
      parity_q     <= parity_d;
      owner_q      <= owner_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign gnt    = gnt_q;
  assign done   = done_q;
  assign parity = parity_q;
  assign owner  = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_xor_parity_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xor_parity_sched
//  Purpose  : Directed self-checking bench for xor_parity_sched (WIDTH=8).
//             Expected parities follow XOR_SCHED_ODD_EN when it is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_xor_parity_sched;

  localparam int WIDTH = 8;

`ifdef XOR_SCHED_ODD_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [3:0]           req;
  logic [4*WIDTH-1:0]   data;
  logic [3:0]           gnt;
  logic                 busy;
  logic                 done;
  logic                 parity;
  logic [1:0]           owner;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  xor_parity_sched #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .data   (data),
    .gnt    (gnt),
    .busy   (busy),
    .done   (done),
    .parity (parity),
    .owner  (owner)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_word(input int id, input logic [7:0] w);
    data[id*WIDTH +: WIDTH] = w;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) for a grant; returns the grant vector and the cycle seen
  task automatic wait_gnt(input string tag, output logic [3:0] g, output int c);
    int t;
    t = 0;
    @(negedge clk);
    while (gnt == 4'b0000 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_gnt_seen"}, 32'(gnt != 4'b0000), 32'd1);
    g = gnt;
    c = cyc;
  endtask

  // Serve one word: check grant, latency to done, result, and return to idle
  task automatic serve(input string tag, input int exp_id, input logic exp_par,
                       input bit drop, output logic [3:0] g, output int c);
    wait_gnt(tag, g, c);
    check({tag, "_gnt"}, 32'(g), 32'(4'b0001 << exp_id));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    if (drop) req[exp_id] = 1'b0;
    @(negedge clk);
    check({tag, "_gnt_pulse"}, 32'(gnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_done_early"}, 32'(done), 32'd0);
    @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_parity"}, 32'(parity), 32'(exp_par ^ ODD));
    check({tag, "_owner"}, 32'(owner), 32'(exp_id));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_hold_par"}, 32'(parity), 32'(exp_par ^ ODD));
  endtask

  initial begin
    logic [3:0] g, prev;
    int c, c_prev;
    bit seen_done;

    rst  = 1'b1;
    req  = 4'b0000;
    data = '0;
    repeat (2) @(negedge clk);
    check("rst_gnt",    32'(gnt),    32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_parity", 32'(parity), 32'd0);
    check("rst_owner",  32'(owner),  32'd0);
    rst = 1'b0;

    // Single request, 0xB5 has five ones
    set_word(0, 8'hB5);
    req = 4'b0001;
    serve("single", 0, 1'b1, 1'b1, g, c);

    // All four requesting from reset, 6-cycle spacing
    set_word(0, 8'h01);
    set_word(1, 8'h03);
    set_word(2, 8'h07);
    set_word(3, 8'h0F);
    req = 4'b1111;
    do_reset();
    serve("all0", 0, 1'b1, 1'b1, g, c_prev);
    serve("all1", 1, 1'b0, 1'b1, g, c);
    check("all_space01", 32'(c - c_prev), 32'd6);
    c_prev = c;
    serve("all2", 2, 1'b1, 1'b1, g, c);
    check("all_space12", 32'(c - c_prev), 32'd6);
    c_prev = c;
    serve("all3", 3, 1'b0, 1'b1, g, c);
    check("all_space23", 32'(c - c_prev), 32'd6);

    // Fairness with 1 and 3 held continuously
    set_word(1, 8'h01);
    set_word(3, 8'h00);
    do_reset();
    req  = 4'b1010;
    prev = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      serve("fair", (i % 2 == 0) ? 1 : 3, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0, g, c);
      check("fair_alternate", 32'(g != prev), 32'd1);
      prev = g;
    end
    req = 4'b0000;

    // Edge data patterns
    set_word(0, 8'h00);
    req = 4'b0001;
    serve("edge00", 0, 1'b0, 1'b1, g, c);
    set_word(0, 8'hFF);
    req = 4'b0001;
    serve("edgeFF", 0, 1'b0, 1'b1, g, c);
    set_word(0, 8'h80);
    req = 4'b0001;
    serve("edge80", 0, 1'b1, 1'b1, g, c);

    // Reset abort: leave a nonzero owner first, then abort requester 2
    set_word(3, 8'h01);
    req = 4'b1000;
    serve("pre_abort", 3, 1'b1, 1'b1, g, c);
    set_word(1, 8'h03);
    set_word(2, 8'hB5);
    req = 4'b0100;
    wait_gnt("abort", g, c);
    check("abort_gnt", 32'(g), 32'b0100);
    req[2] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy",   32'(busy),   32'd0);
    check("abort_owner",  32'(owner),  32'd0);
    check("abort_parity", 32'(parity), 32'd0);
    check("abort_done",   32'(done),   32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    req = 4'b0110;
    serve("post1", 1, 1'b0, 1'b1, g, c);
    serve("post2", 2, 1'b1, 1'b1, g, c);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (checks %0d)", n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
